// File: rtl/wac_cfg_shifter_pkg.sv
// Shared types and constants for the WAC10 configuration shifter.
package wac_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SETUP    = 3'd1,
      SHIFT_HI = 3'd2,
      SHIFT_LO = 3'd3,
      LATCH    = 3'd4
   } stateT;

   // Control codes that belong to the ADC capture path, not to this shifter.
   localparam logic [7:0] CMD_ADC1        = 8'h11;
   localparam logic [7:0] CMD_ADC2        = 8'h12;
   localparam logic [7:0] TGT_NIBBLE_MASK = 8'h0F;

   function automatic logic isAdcCmd(input logic [7:0] ctrl);
      return (ctrl == CMD_ADC1) || (ctrl == CMD_ADC2);
   endfunction

endpackage

// File: rtl/wac_cfg_shifter_if.sv
// Sequencer-facing command inputs plus the serial bus, load lines and status.
// master = control sequencer side, slave = shifter side.
interface wac_cfg_if #(
   parameter int N_TGT  = 4,
   parameter int WORD_W = 16
);
   logic [7:0]        ctrlWac;
   logic [WORD_W-1:0] confWac;
   logic              confWacEn;
   logic              sclk;
   logic              sdata;
   logic              csN;
   logic [N_TGT-1:0]  ld;
   logic              busy;
   logic              done;
   logic              errTgt;
   logic              errOvr;

   modport master (
      output ctrlWac, confWac, confWacEn,
      input  sclk, sdata, csN, ld, busy, done, errTgt, errOvr
   );

   modport slave (
      input  ctrlWac, confWac, confWacEn,
      output sclk, sdata, csN, ld, busy, done, errTgt, errOvr
   );
endinterface

// File: rtl/wac_cfg_shifter_sync_fall.sv
// Two-flop synchronizer plus falling-edge detector for an asynchronous
// active-low strobe. fall is high for exactly one cycle per 1->0 transition
// of the synchronized level; a level held low yields a single pulse.
module wac_sync_fall (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic fall
);
   logic [1:0] syncQ;
   logic       prevQ;

   // Synchronize the strobe and remember its previous synchronized level.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         syncQ <= 2'b11;
         prevQ <= 1'b1;
      end else begin
         syncQ <= {syncQ[0], din};
         prevQ <= syncQ[1];
      end
   end

   assign fall = prevQ & ~syncQ[1];
endmodule

// File: rtl/wac_cfg_shifter.sv
// Serializes a captured configuration word MSB-first onto sclk/sdata/csN and
// then pulses the load line of the selected target. All bus outputs are
// registered from the next-state decode so they are glitch-free.
module wac_cfg_shifter
   import wac_cfg_pkg::*;
#(
   parameter int CLK_DIV = 8,
   parameter int N_TGT   = 4,
   parameter int WORD_W  = 16
) (
   input  logic       clk,
   input  logic       rst,
   wac_cfg_if.slave   bus
);
   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int BIT_W = $clog2(WORD_W);
   localparam int TGT_W = (N_TGT > 1) ? $clog2(N_TGT) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
   localparam logic [3:0]       TGT_MAX  = 4'(N_TGT);

   stateT             state, stateNext;
   logic              startFall;
   logic [DIV_W-1:0]  divCnt;
   logic              tick;
   logic [BIT_W-1:0]  bitCnt;
   logic [WORD_W-1:0] shReg;
   logic [TGT_W-1:0]  tgtIdx;
   logic [3:0]        tgtNib;
   logic              tgtOk;
   logic              accept;
   logic              reject;
   logic              overrun;

   logic              sclkQ;
   logic              csNQ;
   logic              busyQ;
   logic              doneQ;
   logic              errTgtQ;
   logic              errOvrQ;
   logic [N_TGT-1:0]  ldQ;

   wac_sync_fall uSync (
      .clk  (clk),
      .rst  (rst),
      .din  (bus.confWacEn),
      .fall (startFall)
   );

   assign tick   = (divCnt == DIV_LAST);
   assign tgtNib = 4'(bus.ctrlWac & TGT_NIBBLE_MASK);
   assign tgtOk  = (bus.ctrlWac[7:4] == 4'h0) && (tgtNib != 4'h0) && (tgtNib <= TGT_MAX);

   // Classify start requests and compute the next phase of the transfer.
   always_comb begin
      // NOTE: every output of this block is defaulted first so no path can infer a latch.
      stateNext = state;
      accept    = 1'b0;
      reject    = 1'b0;
      overrun   = 1'b0;
      unique case (state)
         IDLE: begin
            if (startFall && !isAdcCmd(bus.ctrlWac)) begin
               if (tgtOk) begin
                  accept    = 1'b1;
                  stateNext = SETUP;
               end else begin
                  reject    = 1'b1;
               end
            end
         end
         SETUP:    if (tick) stateNext = SHIFT_HI;
         SHIFT_HI: if (tick) stateNext = SHIFT_LO;
         SHIFT_LO: if (tick) stateNext = (bitCnt == '0) ? LATCH : SHIFT_HI;
         LATCH:    if (tick) stateNext = IDLE;
         default:  stateNext = IDLE;
      endcase
      if (state != IDLE && startFall) overrun = 1'b1;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   // Phase divider: restarts on every state/phase change, idles at zero.
   always_ff @(posedge clk) begin
      if (rst || state == IDLE || stateNext != state) divCnt <= '0;
      else                                             divCnt <= divCnt + 1'b1;
   end

   // Capture the word and target on acceptance, then shift one bit per sclk period.
   always_ff @(posedge clk) begin
      if (rst) begin
         shReg  <= '0;
         bitCnt <= '0;
         tgtIdx <= '0;
      end else if (accept) begin
         shReg  <= bus.confWac;
         bitCnt <= BIT_LAST;
         tgtIdx <= TGT_W'(tgtNib - 4'd1);
      end else if (state == SHIFT_LO && tick && bitCnt != '0) begin
         shReg  <= {shReg[WORD_W-2:0], 1'b0};
         bitCnt <= bitCnt - 1'b1;
      end else if (state == LATCH && tick) begin
         shReg  <= '0;
      end
   end

   // Registered bus outputs, completion pulse and sticky error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclkQ   <= 1'b0;
         csNQ    <= 1'b1;
         busyQ   <= 1'b0;
         doneQ   <= 1'b0;
         ldQ     <= '0;
         errTgtQ <= 1'b0;
         errOvrQ <= 1'b0;
      end else begin
         sclkQ <= (stateNext == SHIFT_HI);
         csNQ  <= !(stateNext inside {SETUP, SHIFT_HI, SHIFT_LO});
         busyQ <= (stateNext != IDLE);
         doneQ <= (state == LATCH) && tick;
         ldQ   <= '0;
         if (stateNext == LATCH) ldQ[tgtIdx] <= 1'b1;
         if (accept) begin
            errTgtQ <= 1'b0;
            errOvrQ <= 1'b0;
         end else begin
            if (reject)  errTgtQ <= 1'b1;
            if (overrun) errOvrQ <= 1'b1;
         end
      end
   end

   assign bus.sclk   = sclkQ;
   assign bus.sdata  = shReg[WORD_W-1];
   assign bus.csN    = csNQ;
   assign bus.ld     = ldQ;
   assign bus.busy   = busyQ;
   assign bus.done   = doneQ;
   assign bus.errTgt = errTgtQ;
   assign bus.errOvr = errOvrQ;
endmodule

// File: tb/tb_wac_cfg_shifter.sv
// Scoreboard bench for wac_cfg_shifter (CLK_DIV=2, N_TGT=4, WORD_W=16).
// Stimulus pushes the expected word/load value per accepted transfer; the
// monitor rebuilds each transfer from the bus and compares on done.
module tb_wac_cfg_shifter;
   localparam int CLK_DIV = 2;
   localparam int N_TGT   = 4;
   localparam int WORD_W  = 16;

   // Hand-computed transfer shape for CLK_DIV=2, WORD_W=16.
   localparam int BUSY_CYC  = 68;  // (2*16+2)*2
   localparam int CSLOW_CYC = 66;  // SETUP 2 + 32 shift phases * 2
   localparam int LD_CYC    = 2;
   localparam int N_EDGES   = 16;

   typedef struct {
      logic [15:0] word;
      logic [3:0]  ld;
   } expT;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #10 clk = ~clk;

   wac_cfg_if #(.N_TGT(N_TGT), .WORD_W(WORD_W)) bus ();

   wac_cfg_shifter #(.CLK_DIV(CLK_DIV), .N_TGT(N_TGT), .WORD_W(WORD_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   expT sbQ[$];
   int  total = 0;
   int  bad   = 0;

   // Monitor state.
   int          doneCount = 0;
   int          edgeTotal = 0;
   int          busyTotal = 0;
   int          ldTotal   = 0;
   int          curEdges  = 0;
   int          busyCnt   = 0;
   int          csLowCnt  = 0;
   int          ldCnt     = 0;
   int          stableViol = 0;
   logic [3:0]  ldSeen    = '0;
   logic [15:0] shiftIn   = '0;
   logic        prevSclk  = 1'b0;
   logic        prevSdata = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clearAcc();
      curEdges   = 0;
      busyCnt    = 0;
      csLowCnt   = 0;
      ldCnt      = 0;
      stableViol = 0;
      ldSeen     = '0;
      shiftIn    = '0;
   endtask

   // Monitor: samples 1 time unit after each rising edge and scores on done.
   always @(posedge clk) begin
      expT e;
      #1;
      if (bus.busy) begin
         busyTotal++;
         busyCnt++;
      end
      if (bus.sclk && !prevSclk) begin
         edgeTotal++;
         curEdges++;
         shiftIn = {shiftIn[14:0], bus.sdata};
      end
      if (bus.sclk && prevSclk && bus.sdata !== prevSdata) stableViol++;
      if (!bus.csN) csLowCnt++;
      if (bus.ld != '0) begin
         ldTotal++;
         ldCnt++;
         ldSeen = bus.ld;
      end
      if (bus.done) begin
         doneCount++;
         check("sb_pending", 32'(sbQ.size() > 0), 32'd1);
         if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            check("ser_word",    32'(shiftIn),  32'(e.word));
            check("ld_value",    32'(ldSeen),   32'(e.ld));
            check("sclk_edges",  curEdges,      N_EDGES);
            check("busy_cycles", busyCnt,       BUSY_CYC);
            check("csn_low",     csLowCnt,      CSLOW_CYC);
            check("ld_cycles",   ldCnt,         LD_CYC);
            check("sdata_stable", stableViol,   0);
         end
         clearAcc();
      end else if (!bus.busy) begin
         clearAcc();
      end
      prevSclk  = bus.sclk;
      prevSdata = bus.sdata;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulseStart(input logic [7:0] c, input logic [15:0] w, input int lowCycles);
      @(negedge clk);
      bus.ctrlWac   = c;
      bus.confWac   = w;
      bus.confWacEn = 1'b0;
      repeat (lowCycles) @(negedge clk);
      bus.confWacEn = 1'b1;
   endtask

   task automatic expectXfer(input logic [15:0] w, input logic [3:0] l);
      expT e;
      e.word = w;
      e.ld   = l;
      sbQ.push_back(e);
   endtask

   task automatic waitDone(input string name, input int startCount);
      int n = 0;
      while (doneCount == startCount && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check(name, doneCount - startCount, 1);
   endtask

   // Global watchdog so the bench can never hang.
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d, e0, b0, l0, n;
      bus.ctrlWac   = 8'h00;
      bus.confWac   = 16'h0000;
      bus.confWacEn = 1'b1;
      rst = 1'b1;
      idle(3);

      // Reset values.
      check("rst_sclk",   32'(bus.sclk),   32'd0);
      check("rst_sdata",  32'(bus.sdata),  32'd0);
      check("rst_csn",    32'(bus.csN),    32'd1);
      check("rst_ld",     32'(bus.ld),     32'd0);
      check("rst_busy",   32'(bus.busy),   32'd0);
      check("rst_done",   32'(bus.done),   32'd0);
      check("rst_errtgt", 32'(bus.errTgt), 32'd0);
      check("rst_errovr", 32'(bus.errOvr), 32'd0);
      rst = 1'b0;
      idle(4);

      // Basic transfer to target 2.
      expectXfer(16'hA5C3, 4'b0010);
      d = doneCount;
      pulseStart(8'h02, 16'hA5C3, 3);
      waitDone("t1_done", d);
      check("t1_errtgt", 32'(bus.errTgt), 32'd0);
      check("t1_errovr", 32'(bus.errOvr), 32'd0);

      // ADC commands are ignored entirely.
      e0 = edgeTotal;
      b0 = busyTotal;
      pulseStart(8'h11, 16'h1111, 3);
      idle(60);
      pulseStart(8'h12, 16'h2222, 3);
      idle(60);
      check("adc_edges",  edgeTotal - e0, 0);
      check("adc_busy",   busyTotal - b0, 0);
      check("adc_errtgt", 32'(bus.errTgt), 32'd0);
      check("adc_errovr", 32'(bus.errOvr), 32'd0);

      // Out-of-range target sets errTgt with no bus activity.
      e0 = edgeTotal;
      b0 = busyTotal;
      pulseStart(8'h07, 16'h7777, 3);
      idle(60);
      check("bad_errtgt", 32'(bus.errTgt), 32'd1);
      check("bad_edges",  edgeTotal - e0, 0);
      check("bad_busy",   busyTotal - b0, 0);
      pulseStart(8'h20, 16'h2020, 3);
      idle(30);
      check("hi_nib_errtgt", 32'(bus.errTgt), 32'd1);
      // An ADC code leaves the sticky flag alone.
      pulseStart(8'h11, 16'h1111, 3);
      idle(30);
      check("adc_keeps_errtgt", 32'(bus.errTgt), 32'd1);
      // A valid start clears it and transfers to the highest target.
      expectXfer(16'h1234, 4'b1000);
      d = doneCount;
      pulseStart(8'h04, 16'h1234, 3);
      waitDone("t3_done", d);
      check("t3_errtgt", 32'(bus.errTgt), 32'd0);

      // Overrun: second start 10 cycles in, with changed inputs.
      expectXfer(16'h0F0F, 4'b0001);
      d = doneCount;
      pulseStart(8'h01, 16'h0F0F, 1);
      n = 0;
      while (!bus.busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t4_busy_seen", 32'(bus.busy), 32'd1);
      idle(10);
      bus.confWac   = 16'hFFFF;
      bus.ctrlWac   = 8'h03;
      bus.confWacEn = 1'b0;
      idle(3);
      bus.confWacEn = 1'b1;
      waitDone("t4_done", d);
      check("t4_errovr", 32'(bus.errOvr), 32'd1);
      check("t4_errtgt", 32'(bus.errTgt), 32'd0);
      idle(30);
      check("t4_single", doneCount - d, 1);

      // Level held low for 500 cycles gives exactly one transfer.
      expectXfer(16'h8001, 4'b0100);
      d = doneCount;
      pulseStart(8'h03, 16'h8001, 500);
      idle(100);
      check("hold_single",  doneCount - d, 1);
      check("hold_errovr",  32'(bus.errOvr), 32'd0);

      // One-cycle low pulse: caught once, never twice.
      expectXfer(16'h3C3C, 4'b0001);
      d = doneCount;
      pulseStart(8'h01, 16'h3C3C, 1);
      waitDone("short_done", d);
      idle(100);
      check("short_single", doneCount - d, 1);

      // Sub-cycle glitch between clock edges is never sampled.
      d  = doneCount;
      e0 = edgeTotal;
      @(negedge clk);
      #2 bus.confWacEn = 1'b0;
      #3 bus.confWacEn = 1'b1;
      idle(100);
      check("glitch_done",  doneCount - d, 0);
      check("glitch_edges", edgeTotal - e0, 0);

      // Reset while bit 7 (ninth bit) is on the bus aborts cleanly.
      d  = doneCount;
      l0 = ldTotal;
      pulseStart(8'h02, 16'hBEEF, 3);
      n = 0;
      while (curEdges != 9 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("abort_reach_bit7", curEdges, 9);
      rst = 1'b1;
      @(negedge clk);
      check("abort_csn",   32'(bus.csN),   32'd1);
      check("abort_sclk",  32'(bus.sclk),  32'd0);
      check("abort_busy",  32'(bus.busy),  32'd0);
      check("abort_ld",    32'(bus.ld),    32'd0);
      check("abort_done",  32'(bus.done),  32'd0);
      check("abort_sdata", 32'(bus.sdata), 32'd0);
      rst = 1'b0;
      idle(80);
      check("abort_no_done", doneCount - d, 0);
      check("abort_no_ld",   ldTotal - l0, 0);

      // A fresh start after the abort transfers correctly.
      expectXfer(16'h5AA5, 4'b0010);
      d = doneCount;
      pulseStart(8'h02, 16'h5AA5, 3);
      waitDone("post_abort_done", d);

      // Start coinciding with the done cycle is accepted: back-to-back.
      expectXfer(16'hC001, 4'b0001);
      expectXfer(16'h00FF, 4'b0100);
      d = doneCount;
      pulseStart(8'h01, 16'hC001, 3);
      n = 0;
      while (curEdges != 16 && n < 200) begin
         @(negedge clk);
         n++;
      end
      // Last bit is out; time the second request so it is recognized on the done cycle.
      idle(4);
      bus.ctrlWac   = 8'h03;
      bus.confWac   = 16'h00FF;
      bus.confWacEn = 1'b0;
      idle(3);
      bus.confWacEn = 1'b1;
      waitDone("b2b_first", d);
      waitDone("b2b_second", d + 1);
      check("b2b_errovr", 32'(bus.errOvr), 32'd0);

      idle(10);
      check("sb_empty", sbQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
